// File: rtl/cdr_pi_controller.sv
// CDR loop controller: decimates bang-bang PD votes, runs a PI update on a
// wrapping phase accumulator and sequences IDLE/ACQ/TRACK/HOLD with lock.
module cdr_pi_controller #(
  parameter int FINE_W      = 4,
  parameter int DEC_LEN     = 8,
  parameter int KP_ACQ      = 4,
  parameter int KP_TRK      = 1,
  parameter int KI_SHIFT    = 4,
  parameter int INT_W       = 12,
  parameter int LOCK_TH     = 2,
  parameter int LOCK_WINS   = 4,
  parameter int UNLOCK_TH   = 6,
  parameter int UNLOCK_WINS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pd_valid,
  input  logic              up,
  input  logic              dn,
  input  logic              freeze,
  input  logic              ovr_en,
  input  logic [FINE_W+1:0] ovr_code,
  output logic [1:0]        pi_quad,
  output logic [FINE_W-1:0] pi_fine,
  output logic              pi_upd,
  output logic              lock,
  output logic [1:0]        state
);

  localparam int PH_W  = FINE_W + 2;
  localparam int CNT_W = $clog2(DEC_LEN);
  localparam int SUM_W = CNT_W + 2;
  localparam int LW    = INT_W + 2;
  localparam int QC_W  = $clog2(LOCK_WINS + 1);
  localparam int NC_W  = $clog2(UNLOCK_WINS + 1);
  localparam logic signed [LW-1:0] INT_MAX   = LW'((2 ** (INT_W - 1)) - 1);
  localparam logic signed [LW-1:0] DELTA_MAX = LW'(2 ** FINE_W);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, HOLD = 2'd3} state_e;

  state_e                   state_q, state_d, saved_q, saved_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic signed [INT_W-1:0]  intAcc_q, intAcc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [QC_W-1:0]          quiet_q, quiet_d;
  logic [NC_W-1:0]          noisy_q, noisy_d;
  logic                     lock_q, lock_d;
  logic                     upd_q, upd_d;

  logic signed [SUM_W-1:0]  vote, winSum, absSum;
  logic signed [LW-1:0]     intWide, intSat, intShift, kp, prop, deltaRaw, deltaClamp;
  logic signed [INT_W-1:0]  intNew;
  logic [PH_W-1:0]          deltaPh;
  logic                     quietWin, noisyWin, lastSample, run;

  // Window-close arithmetic, evaluated every cycle on the window including the current vote
  always_comb begin
    vote = '0;
    if (up && !dn)      vote = SUM_W'(1);
    else if (dn && !up) vote = '1;
    winSum   = sum_q + vote;
    absSum   = winSum[SUM_W-1] ? -winSum : winSum;
    quietWin = (absSum <= SUM_W'(LOCK_TH));
    noisyWin = (absSum > SUM_W'(UNLOCK_TH));

    intWide = LW'(intAcc_q) + LW'(winSum);
    intSat  = intWide;
    if (intWide > INT_MAX)       intSat = INT_MAX;
    else if (intWide < -INT_MAX) intSat = -INT_MAX;
    intNew   = INT_W'(intSat);
    intShift = LW'(intNew) >>> KI_SHIFT;

    kp   = (state_q == TRACK) ? LW'(KP_TRK) : LW'(KP_ACQ);
    prop = '0;
    if (winSum > 0)      prop = kp;
    else if (winSum < 0) prop = -kp;

    deltaRaw   = prop + intShift;
    deltaClamp = deltaRaw;
    if (deltaRaw > DELTA_MAX)       deltaClamp = DELTA_MAX;
    else if (deltaRaw < -DELTA_MAX) deltaClamp = -DELTA_MAX;
    deltaPh    = PH_W'(deltaClamp);
    lastSample = (cnt_q == CNT_W'(DEC_LEN - 1));
  end

  // Priority: override, then disable, then freeze/hold, then window accumulation
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    phase_d  = phase_q;
    intAcc_d = intAcc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    quiet_d  = quiet_q;
    noisy_d  = noisy_q;
    lock_d   = lock_q;
    upd_d    = 1'b0;
    run      = 1'b0;

    if (ovr_en) begin
      phase_d  = ovr_code;
      upd_d    = (ovr_code != phase_q);
      intAcc_d = '0;
      cnt_d    = '0;
      sum_d    = '0;
      quiet_d  = '0;
      noisy_d  = '0;
      lock_d   = 1'b0;
    end else if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sum_d   = '0;
      quiet_d = '0;
      noisy_d = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          run     = 1'b1;
        end
        ACQ, TRACK: begin
          if (freeze) begin
            state_d = HOLD;
            saved_d = state_q;
            cnt_d   = '0;
            sum_d   = '0;
          end else begin
            run = 1'b1;
          end
        end
        HOLD: if (!freeze) state_d = saved_q;
        default: state_d = IDLE;
      endcase

      if (run && pd_valid) begin
        if (lastSample) begin
          cnt_d    = '0;
          sum_d    = '0;
          intAcc_d = intNew;
          phase_d  = phase_q + deltaPh;
          upd_d    = (deltaClamp != '0);
          if (state_q == TRACK) begin
            quiet_d = '0;
            if (!noisyWin) begin
              noisy_d = '0;
            end else if (noisy_q == NC_W'(UNLOCK_WINS - 1)) begin
              noisy_d = '0;
              state_d = ACQ;
              lock_d  = 1'b0;
            end else begin
              noisy_d = noisy_q + NC_W'(1);
            end
          end else begin
            noisy_d = '0;
            if (!quietWin) begin
              quiet_d = '0;
            end else if (quiet_q == QC_W'(LOCK_WINS - 1)) begin
              quiet_d = '0;
              state_d = TRACK;
              lock_d  = 1'b1;
            end else begin
              quiet_d = quiet_q + QC_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          sum_d = winSum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      saved_q  <= IDLE;
      phase_q  <= '0;
      intAcc_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      quiet_q  <= '0;
      noisy_q  <= '0;
      lock_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      phase_q  <= phase_d;
      intAcc_q <= intAcc_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      quiet_q  <= quiet_d;
      noisy_q  <= noisy_d;
      lock_q   <= lock_d;
      upd_q    <= upd_d;
    end
  end

  assign pi_quad = phase_q[PH_W-1:FINE_W];
  assign pi_fine = phase_q[FINE_W-1:0];
  assign pi_upd  = upd_q;
  assign lock    = lock_q;
  assign state   = state_q;

endmodule

// File: doc/cdr_pi_controller.md
# cdr_pi_controller

Digital loop controller for the CDR phase interpolator. It takes early/late votes from the bang-bang phase detector and decimates them into windows. A proportional-integral update runs on a modular phase accumulator, and the result drives the PI as a quadrant select (clk_0/90/180/270 pair) plus a fine interpolation code. Acquisition/tracking/hold sequencing and the lock indication are also owned here. The block sits between the phase detector and the phase interpolator inside the CDR loop and runs on the recovered PI clock domain.

## Interface
- FINE_W, 4, fine code width; phase accumulator PH_W = FINE_W+2 bits (64 positions/UI at default)
- DEC_LEN, 8, valid PD samples per decision window (power of 2, ≥2)
- KP_ACQ, 4, proportional step in ACQ
- KP_TRK, 1, proportional step in TRACK
- KI_SHIFT, 4, integral path right-shift
- INT_W, 12, integral accumulator width (signed)
- LOCK_TH, 2, |sum| ≤ LOCK_TH counts toward lock
- LOCK_WINS, 4, consecutive quiet windows to declare lock
- UNLOCK_TH, 6, |sum| > UNLOCK_TH counts toward loss of lock
- UNLOCK_WINS, 2, consecutive noisy windows to drop lock

- clk  in  1  loop clock (PI output clock)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  loop enable
- pd_valid  in  1  up/dn qualify strobe
- up  in  1  PD late vote (advance phase)
- dn  in  1  PD early vote (retard phase)
- freeze  in  1  hold current code
- ovr_en  in  1  manual code override
- ovr_code  in  PH_W  override phase
- pi_quad  out  2  quadrant select = phase[PH_W-1:FINE_W]
- pi_fine  out  FINE_W  fine code = phase[FINE_W-1:0]
- pi_upd  out  1  one-cycle pulse when the code changes source/value
- lock  out  1  lock indicator
- state  out  2  IDLE=0, ACQ=1, TRACK=2, HOLD=3

## Operation
- Vote: on pd_valid, up&~dn → +1, dn&~up → −1, otherwise 0 (the sample still counts toward DEC_LEN). Sum is signed, log2(DEC_LEN)+2 bits.
- Window close: on the DEC_LEN-th valid sample in ACQ/TRACK:
  - int_acc ← sat(int_acc + sum), saturating at ±(2^(INT_W-1)−1).
  - prop = KP(state) · sign(sum), where KP is taken from the state before the update; prop = 0 if sum = 0.
  - delta = prop + (new int_acc >>> KI_SHIFT), clamped to ±2^FINE_W.
  - phase ← (phase + delta) mod 2^PH_W.
  - Window counter and sum clear.
- States:
  - IDLE: loop frozen, code held. IDLE→ACQ when en=1.
  - ACQ→TRACK after LOCK_WINS consecutive quiet windows; lock←1 at that update.
  - TRACK→ACQ after UNLOCK_WINS consecutive noisy windows; lock←0 at that update.
  - Quiet/noisy counters reset on any window that does not qualify.
  - freeze=1 in ACQ/TRACK → HOLD. Partial window is discarded, phase and int_acc are held, lock is held. freeze=0 → return to the saved state.
  - en=0 → IDLE from any state. lock←0, window cleared, phase held.
- Override (highest priority): while ovr_en=1, phase ← ovr_code every cycle, int_acc←0, window and lock counters clear, lock←0. State is unchanged but no loop updates occur. After release, the loop resumes from ovr_code.

## Timing
- Reset: pi_quad=0, pi_fine=0, pi_upd=0, lock=0, state=IDLE, phase=0, int_acc=0, counters=0.
- Loop update latency: the outputs and pi_upd reflect the new phase 1 cycle after the clock edge that samples the closing vote.
- pi_upd pulses for one cycle:
  - on each window update where delta ≠ 0;
  - on each override cycle where ovr_code differs from the current phase.
- The integral accumulator saturates and never wraps. The phase accumulator always wraps; for example, quadrant 3→0 is a legal wrap.
- Simultaneous events: ovr_en > en=0 > freeze > window close. A closing vote coincident with freeze or en=0 is discarded.
- A vote with pd_valid coincident with the ACQ entry cycle is counted.

## Test plan
- Reset mid-window: assert rst_n=0 after 5 votes → all outputs 0, state=0 asynchronously. After release and en=1, the first window needs 8 fresh samples.
- Acquisition step from reset, en=1, 8 samples up=1 → sum=+8, int_acc=8, delta=4. Phase 4: pi_quad=0, pi_fine=4, with a pi_upd pulse 1 cycle after the 8th sample.
- Wrap: ovr_code=62 with ovr_en for 2 cycles, then release in ACQ. Then 8 up votes → phase 2: pi_quad=0, pi_fine=2.
- Lock and unlock:
  - From reset, 4 windows of 4 up + 4 dn → lock=1, state=TRACK, phase=0.
  - Then 2 windows of all-up: first → phase 1; second → phase 3, lock=0, state=ACQ.
- Freeze: assert freeze after 3 votes of a window → state=HOLD, no pi_upd, code held. On release, 8 up votes are needed for the next update; the 3 prior votes are ignored.
- Priority: ovr_en=1 and freeze=1 together with ovr_code=17 → pi_quad=1, pi_fine=1 one cycle later, lock=0.
